// File: rtl/fft_norm_pkg.sv
// ----------------------------------------------------------------------------
// fft_norm_pkg
//
// Shared definitions for the block-floating-point normalizer.
//   - headroom()  : leading-sign-bit count of a W-bit signed word (W <= 64)
//   - exp_width() : width of an exponent that must hold 0..W-1
//   - rd_state_e  : read-side FSM states of block_normalize
//
// No ports (package).
// ----------------------------------------------------------------------------
package fft_norm_pkg;

    // Widest sample the headroom function can handle. Callers zero-extend
    // their W-bit word into this container and pass W alongside it.
    localparam int HR_MAX_W = 64;
    localparam int HR_IDX_W = $clog2(HR_MAX_W);

    // Read FSM: either waiting for a completed frame or streaming one out.
    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    // Exponent width that can hold every legal shift 0..w-1.
    function automatic int exp_width(input int w);
        return $clog2(w);
    endfunction

    // Count the bits directly below the sign bit that equal the sign bit.
    // The w-bit word arrives right-aligned in a HR_MAX_W container; it is
    // left-aligned first so the sign bit always sits at the top, and the
    // scan is limited to the w-1 bits that belong to the word.
    function automatic int headroom(input logic [HR_MAX_W-1:0] x, input int w);
        logic [HR_MAX_W-1:0] xl;
        logic                msb;
        logic                run;
        int                  cnt;
        xl  = x << (HR_MAX_W - w);
        msb = xl[HR_MAX_W-1];
        run = 1'b1;
        cnt = 0;
        for (int i = HR_MAX_W - 2; i >= 0; i--) begin
            if (run && ((HR_MAX_W - 1 - i) < w)) begin
                if (xl[HR_IDX_W'(i)] == msb) begin
                    cnt = cnt + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/norm_pingpong_ram.sv
// ----------------------------------------------------------------------------
// norm_pingpong_ram
//
// Two-bank simple dual-port RAM used as the frame ping-pong buffer. One write
// port, one read port, read data registered (1-cycle read latency) so the
// array maps onto block RAM. Bank select is the MSB of the physical address.
//
// Ports:
//   mclk     in   clock, all logic on posedge
//   wr_en    in   write strobe
//   wr_bank  in   bank written
//   wr_addr  in   ADDR_W  word address within the bank
//   wr_data  in   DATA_W  write data
//   rd_en    in   read strobe; rd_data updates only when high
//   rd_bank  in   bank read
//   rd_addr  in   ADDR_W  word address within the bank
//   rd_data  out  DATA_W  registered read data
// ----------------------------------------------------------------------------
module norm_pingpong_ram
    import fft_norm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              mclk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset so it can be inferred as block RAM; the read
    // register is only consumed when the pipeline marks it valid.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/block_normalize.sv
// ----------------------------------------------------------------------------
// block_normalize
//
// Block-floating-point normalizer. Buffers one frame of N complex samples in
// a ping-pong RAM while tracking the smallest headroom over every real and
// imaginary part, then replays the frame shifted left by that common amount
// together with the frame exponent.
//
// Build option:
//   BLOCK_NORM_GUARD_EN  when defined, the exponent is one less than the
//                        minimum headroom (floored at 0), keeping one guard
//                        bit for the next butterfly. Undefined: full
//                        normalization.
//
// Ports:
//   mclk     in   clock, all logic on posedge
//   i_rst_n  in   asynchronous active-low reset
//   i_init   in   synchronous flush of the partial frame and any replay
//   i_vld    in   input sample valid (no backpressure, gaps allowed)
//   i_re     in   W      signed real part
//   i_im     in   W      signed imaginary part
//   o_vld    out  output sample valid
//   o_sof    out  first output sample of a frame
//   o_re     out  W      real part shifted left by o_exp
//   o_im     out  W      imaginary part shifted left by o_exp
//   o_exp    out  EXP_W  frame shift amount, constant across the frame
//
// Latency: last input sample captured at edge t, output sample k registered
// at edge t+2+k.
// ----------------------------------------------------------------------------
module block_normalize
    import fft_norm_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 6,
    parameter int EXP_W  = exp_width(W)
) (
    input  logic             mclk,
    input  logic             i_rst_n,
    input  logic             i_init,
    input  logic             i_vld,
    input  logic [W-1:0]     i_re,
    input  logic [W-1:0]     i_im,
    output logic             o_vld,
    output logic             o_sof,
    output logic [W-1:0]     o_re,
    output logic [W-1:0]     o_im,
    output logic [EXP_W-1:0] o_exp
);

    localparam logic [LOG2_N-1:0] ADDR_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] ADDR_LAST = '1;

    // Write side
    logic [LOG2_N-1:0] wr_cnt_q;
    logic              wr_bank_q;
    logic [EXP_W-1:0]  run_min_q;
    logic              wr_en;
    logic              frame_done;

    // Headroom of the incoming sample and the frame minimum including it
    logic [EXP_W-1:0]  hr_re;
    logic [EXP_W-1:0]  hr_im;
    logic [EXP_W-1:0]  min_sample;
    logic [EXP_W-1:0]  min_frame;
    logic [EXP_W-1:0]  exp_new;

    // Read side
    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [LOG2_N-1:0] rd_addr_q;
    logic [LOG2_N-1:0] rd_addr_d;
    logic              rd_en;
    logic              rd_bank_q;
    logic [EXP_W-1:0]  rd_exp_q;

    // RAM output stage bookkeeping
    logic [2*W-1:0]    ram_rd_data;
    logic [W-1:0]      ram_re;
    logic [W-1:0]      ram_im;
    logic              vld1_q;
    logic              sof1_q;
    logic [EXP_W-1:0]  exp1_q;

    // A sample that coincides with i_init is dropped, so it neither writes
    // the RAM nor counts towards a frame.
    assign wr_en      = i_vld & ~i_init;
    assign frame_done = wr_en & (wr_cnt_q == ADDR_LAST);

    assign hr_re = EXP_W'(headroom(HR_MAX_W'(i_re), W));
    assign hr_im = EXP_W'(headroom(HR_MAX_W'(i_im), W));

    // The running minimum reloads on the first sample of a frame, so the
    // value folded in at address 0 ignores whatever the tracker holds.
    always_comb begin
        min_sample = (hr_re < hr_im) ? hr_re : hr_im;
        if (wr_cnt_q == '0) begin
            min_frame = min_sample;
        end else begin
            min_frame = (run_min_q < min_sample) ? run_min_q : min_sample;
        end
    end

    // Frame exponent derived from the final minimum.
`ifdef BLOCK_NORM_GUARD_EN
    assign exp_new = (min_frame == '0) ? '0 : min_frame - EXP_W'(1);
`else
    assign exp_new = min_frame;
`endif

    // Write counter, bank toggle and minimum tracker. On frame completion
    // the filled bank and its exponent are handed to the read side; these
    // hand-off registers update at the same edge the last drain read of the
    // previous frame is issued, which is safe because that read has already
    // captured its bank/exponent into the pipeline.
    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            run_min_q <= '0;
            rd_bank_q <= 1'b0;
            rd_exp_q  <= '0;
        end else if (i_init) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            run_min_q <= '0;
        end else if (i_vld) begin
            wr_cnt_q  <= wr_cnt_q + ADDR_ONE;
            run_min_q <= min_frame;
            if (frame_done) begin
                wr_bank_q <= ~wr_bank_q;
                rd_bank_q <= wr_bank_q;
                rd_exp_q  <= exp_new;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RD_IDLE;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Read FSM next state. DRAIN walks every address once with no gaps; a
    // frame completing on the last drain cycle chains straight into the
    // next drain so continuous input yields continuous output.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_en     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (frame_done) begin
                    state_d   = RD_DRAIN;
                    rd_addr_d = '0;
                end
            end
            RD_DRAIN: begin
                rd_en = 1'b1;
                if (rd_addr_q == ADDR_LAST) begin
                    rd_addr_d = '0;
                    state_d   = frame_done ? RD_DRAIN : RD_IDLE;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d   = RD_IDLE;
                rd_addr_d = '0;
            end
        endcase
        if (i_init) begin
            state_d   = RD_IDLE;
            rd_addr_d = '0;
        end
    end

    norm_pingpong_ram #(
        .DATA_W (2 * W),
        .ADDR_W (LOG2_N)
    ) u_ram (
        .mclk    (mclk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_cnt_q),
        .wr_data ({i_re, i_im}),
        .rd_en   (rd_en),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rd_data)
    );

    assign ram_re = ram_rd_data[2*W-1:W];
    assign ram_im = ram_rd_data[W-1:0];

    // Side-band that travels alongside the RAM read: valid, start-of-frame
    // and the exponent of the frame being drained. The exponent is sampled
    // here rather than at the output because the hand-off register may
    // already hold the next frame's value by then.
    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld1_q <= 1'b0;
            sof1_q <= 1'b0;
            exp1_q <= '0;
        end else begin
            vld1_q <= rd_en & ~i_init;
            sof1_q <= rd_en & ~i_init & (rd_addr_q == '0);
            if (rd_en) begin
                exp1_q <= rd_exp_q;
            end
        end
    end

    // Output register. Data and exponent only move with a valid sample, so
    // they hold their last values through idle gaps. The left shift is
    // exact because the exponent never exceeds any sample's headroom.
    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld <= 1'b0;
            o_sof <= 1'b0;
            o_re  <= '0;
            o_im  <= '0;
            o_exp <= '0;
        end else begin
            o_vld <= vld1_q & ~i_init;
            o_sof <= sof1_q & ~i_init;
            if (vld1_q && !i_init) begin
                o_re  <= ram_re << exp1_q;
                o_im  <= ram_im << exp1_q;
                o_exp <= exp1_q;
            end
        end
    end

endmodule

// File: tb/tb_block_normalize.sv
// ----------------------------------------------------------------------------
// tb_block_normalize
//
// Self-checking bench for block_normalize with W=16, LOG2_N=2 (N=4).
// A frame-level reference model predicts every output sample and the edge
// it must appear on; a compare process checks the DUT each cycle. Directed
// frames pin literal values, then randomized traffic with gaps, flushes and
// resets exercises the rest. Honours BLOCK_NORM_GUARD_EN like the design.
// ----------------------------------------------------------------------------
module tb_block_normalize;

    localparam int W      = 16;
    localparam int LOG2_N = 2;
    localparam int N      = 4;
    localparam int EXP_W  = 4;

    logic             mclk    = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_init  = 1'b0;
    logic             i_vld   = 1'b0;
    logic [W-1:0]     i_re    = '0;
    logic [W-1:0]     i_im    = '0;
    logic             o_vld;
    logic             o_sof;
    logic [W-1:0]     o_re;
    logic [W-1:0]     o_im;
    logic [EXP_W-1:0] o_exp;

    typedef struct {
        int               due;
        logic [W-1:0]     re;
        logic [W-1:0]     im;
        logic [EXP_W-1:0] e;
        logic             sof;
    } exp_t;

    typedef struct {
        int               cyc;
        logic [W-1:0]     re;
        logic [EXP_W-1:0] e;
        logic             sof;
    } obs_t;

    exp_t             exp_q[$];
    obs_t             obs_q[$];
    int               fr_re[$];
    int               fr_im[$];
    int               cyc           = 0;
    int               last_done_cyc = 0;
    int               tests_run     = 0;
    int               tests_failed  = 0;
    logic [W-1:0]     held_re       = '0;
    logic [W-1:0]     held_im       = '0;
    logic [EXP_W-1:0] held_exp      = '0;

    block_normalize #(
        .W      (W),
        .LOG2_N (LOG2_N),
        .EXP_W  (EXP_W)
    ) dut (
        .mclk    (mclk),
        .i_rst_n (i_rst_n),
        .i_init  (i_init),
        .i_vld   (i_vld),
        .i_re    (i_re),
        .i_im    (i_im),
        .o_vld   (o_vld),
        .o_sof   (o_sof),
        .o_re    (o_re),
        .o_im    (o_im),
        .o_exp   (o_exp)
    );

    always #5 mclk = ~mclk;

    // Headroom as "how many top bits can be dropped and the value still
    // fits": largest k with -2^(W-1-k) <= v < 2^(W-1-k).
    function automatic int ref_hr(input logic [W-1:0] x);
        int v;
        int best;
        int lim;
        v    = int'($signed(x));
        best = 0;
        for (int k = 0; k < W; k++) begin
            lim = 1 << (W - 1 - k);
            if (v >= -lim && v < lim) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Scale by 2^e in plain integer arithmetic and keep W bits.
    function automatic logic [W-1:0] ref_scale(input logic [W-1:0] x, input int e);
        int v;
        v = int'($signed(x)) * (1 << e);
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_sample(input int sh);
        logic [W-1:0] r;
        r = W'($urandom);
        if ($urandom_range(15, 0) == 0) begin
            r = 16'h8000;
        end
        return W'($signed(r) >>> sh);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [W-1:0] re,
                                 input logic [W-1:0] im, input logic init);
        @(negedge mclk);
        i_vld  = vld;
        i_re   = re;
        i_im   = im;
        i_init = init;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic sendFrame(input int re[N], input int im[N], input bit gaps);
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, W'(re[k]), W'(im[k]), 1'b0);
            if (gaps) begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic doReset();
        @(negedge mclk);
        #1;
        i_rst_n = 1'b0;
        i_vld   = 1'b0;
        i_init  = 1'b0;
        @(negedge mclk);
        checkOutput("reset_o_vld", 32'(o_vld), 0);
        checkOutput("reset_o_re", 32'(o_re), 0);
        checkOutput("reset_o_exp", 32'(o_exp), 0);
        #1;
        i_rst_n = 1'b1;
    endtask

    // Compare the last captured frame against hand-computed values.
    task automatic checkLit(input string tag, input int req_e, input int req_re[N]);
        checkOutput({tag, "_count"}, obs_q.size(), N);
        for (int k = 0; k < N; k++) begin
            if (k < obs_q.size()) begin
                checkOutput({tag, "_re"}, 32'(obs_q[k].re), 32'(req_re[k] & 16'hFFFF));
                checkOutput({tag, "_exp"}, 32'(obs_q[k].e), req_e);
            end
        end
        if (obs_q.size() > 0) begin
            checkOutput({tag, "_sof"}, 32'(obs_q[0].sof), 1);
            checkOutput({tag, "_latency"}, obs_q[0].cyc, last_done_cyc + 2);
        end
    endtask

    // Reference model: assembles frames from accepted samples and, when a
    // frame is complete, schedules all N outputs at their required edges.
    initial begin
        int   m;
        int   e;
        exp_t x;
        forever begin
            @(posedge mclk);
            cyc++;
            if (!i_rst_n) begin
                fr_re.delete();
                fr_im.delete();
                exp_q.delete();
                held_re  = '0;
                held_im  = '0;
                held_exp = '0;
            end else if (i_init) begin
                fr_re.delete();
                fr_im.delete();
                exp_q.delete();
            end else if (i_vld) begin
                fr_re.push_back(int'($signed(i_re)));
                fr_im.push_back(int'($signed(i_im)));
                if (fr_re.size() == N) begin
                    m = W - 1;
                    for (int k = 0; k < N; k++) begin
                        if (ref_hr(W'(fr_re[k])) < m) m = ref_hr(W'(fr_re[k]));
                        if (ref_hr(W'(fr_im[k])) < m) m = ref_hr(W'(fr_im[k]));
                    end
`ifdef BLOCK_NORM_GUARD_EN
                    e = (m > 0) ? m - 1 : 0;
`else
                    e = m;
`endif
                    for (int k = 0; k < N; k++) begin
                        x.due = cyc + 2 + k;
                        x.re  = ref_scale(W'(fr_re[k]), e);
                        x.im  = ref_scale(W'(fr_im[k]), e);
                        x.e   = EXP_W'(e);
                        x.sof = (k == 0);
                        exp_q.push_back(x);
                    end
                    last_done_cyc = cyc;
                    fr_re.delete();
                    fr_im.delete();
                end
            end
        end
    end

    // Compare process: on each cycle either the scheduled sample is present
    // or the outputs must be idle and holding the last delivered values.
    initial begin
        exp_t x;
        obs_t o;
        forever begin
            @(negedge mclk);
            if (o_vld) begin
                o.cyc = cyc;
                o.re  = o_re;
                o.e   = o_exp;
                o.sof = o_sof;
                obs_q.push_back(o);
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checkOutput("missed_sample", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                x = exp_q.pop_front();
                checkOutput("o_vld", 32'(o_vld), 1);
                checkOutput("o_sof", 32'(o_sof), 32'(x.sof));
                checkOutput("o_re", 32'(o_re), 32'(x.re));
                checkOutput("o_im", 32'(o_im), 32'(x.im));
                checkOutput("o_exp", 32'(o_exp), 32'(x.e));
                held_re  = x.re;
                held_im  = x.im;
                held_exp = x.e;
            end else begin
                checkOutput("o_vld_idle", 32'(o_vld), 0);
                checkOutput("o_sof_idle", 32'(o_sof), 0);
                checkOutput("o_re_hold", 32'(o_re), 32'(held_re));
                checkOutput("o_im_hold", 32'(o_im), 32'(held_im));
                checkOutput("o_exp_hold", 32'(o_exp), 32'(held_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  sh;
        bit  dense;
        logic v;
        logic ini;
`ifdef BLOCK_NORM_GUARD_EN
        int  e_small = 11;
        int  e_zero  = 14;
        int  lit_small[N] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000};
        int  lit_neg1[N]  = '{16'hC000, 0, 0, 0};
        int  lit_fours[N] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
`else
        int  e_small = 12;
        int  e_zero  = 15;
        int  lit_small[N] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        int  lit_neg1[N]  = '{16'h8000, 0, 0, 0};
        int  lit_fours[N] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
`endif
        int  lit_zero[N]  = '{0, 0, 0, 0};
        int  lit_big[N]   = '{3, 16'hFFFB, 7, 1};

        // Pin the reference headroom against hand-computed values.
        checkOutput("hr_0000", ref_hr(16'h0000), 15);
        checkOutput("hr_ffff", ref_hr(16'hFFFF), 15);
        checkOutput("hr_0004", ref_hr(16'h0004), 12);
        checkOutput("hr_c000", ref_hr(16'hC000), 1);
        checkOutput("hr_4000", ref_hr(16'h4000), 0);
        checkOutput("hr_8000", ref_hr(16'h8000), 0);

        repeat (3) @(negedge mclk);
        checkOutput("reset_o_vld", 32'(o_vld), 0);
        checkOutput("reset_o_sof", 32'(o_sof), 0);
        checkOutput("reset_o_im", 32'(o_im), 0);
        #1;
        i_rst_n = 1'b1;
        idle(2);

        $display("[TB] small-magnitude frame");
        obs_q.delete();
        sendFrame('{1, 2, 3, 4}, '{0, 0, 0, 0}, 1'b0);
        idle(8);
        checkLit("small", e_small, lit_small);

        $display("[TB] all-zero and minus-one frames");
        obs_q.delete();
        sendFrame('{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
        idle(8);
        checkLit("zero", e_zero, lit_zero);
        obs_q.delete();
        sendFrame('{-1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
        idle(8);
        checkLit("neg1", e_zero, lit_neg1);

        $display("[TB] full-scale frame");
        obs_q.delete();
        sendFrame('{3, -5, 7, 1}, '{2, 1, -32768, -2}, 1'b0);
        idle(8);
        checkLit("big", 0, lit_big);

        $display("[TB] back-to-back frames then gapped frame");
        obs_q.delete();
        sendFrame('{1, 2, 3, 4}, '{0, 0, 0, 0}, 1'b0);
        sendFrame('{3, -5, 7, 1}, '{2, 1, -32768, -2}, 1'b0);
        sendFrame('{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);
        sendFrame('{4, 4, 4, 4}, '{4, 4, 4, 4}, 1'b1);
        idle(10);
        checkOutput("b2b_count", obs_q.size(), 4 * N);
        if (obs_q.size() >= 3 * N) begin
            checkOutput("b2b_exp0", 32'(obs_q[0].e), e_small);
            checkOutput("b2b_exp1", 32'(obs_q[N].e), 0);
            checkOutput("b2b_exp2", 32'(obs_q[2*N].e), e_zero);
            for (int k = 1; k < 3 * N; k++) begin
                checkOutput("b2b_gapfree", obs_q[k].cyc, obs_q[0].cyc + k);
            end
        end

        $display("[TB] flush mid-frame, then flush mid-drain");
        applyStimulus(1'b1, 16'h0007, 16'h0007, 1'b0);
        applyStimulus(1'b1, 16'h0007, 16'h0007, 1'b0);
        applyStimulus(1'b1, 16'h4000, 16'h4000, 1'b1);
        obs_q.delete();
        sendFrame('{4, 4, 4, 4}, '{4, 4, 4, 4}, 1'b0);
        idle(8);
        checkLit("flush", e_small, lit_fours);
        obs_q.delete();
        sendFrame('{4, 4, 4, 4}, '{4, 4, 4, 4}, 1'b0);
        idle(2);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(6);
        checkOutput("drain_flush_count", obs_q.size(), 1);

        $display("[TB] reset mid-frame and mid-drain");
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0);
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0);
        doReset();
        obs_q.delete();
        sendFrame('{4, 4, 4, 4}, '{4, 4, 4, 4}, 1'b0);
        idle(8);
        checkLit("post_reset", e_small, lit_fours);
        sendFrame('{1, 2, 3, 4}, '{0, 0, 0, 0}, 1'b0);
        idle(2);
        doReset();
        idle(6);

        $display("[TB] randomized traffic");
        sh    = 0;
        dense = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ((c % 16) == 0) begin
                sh    = $urandom_range(W - 1, 0);
                dense = ($urandom_range(1, 0) == 1);
            end
            v   = dense ? 1'b1 : 1'($urandom_range(1, 0));
            ini = ($urandom_range(79, 0) == 0);
            applyStimulus(v, rand_sample(sh), rand_sample(sh), ini);
        end
        idle(N + 6);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
